bcd_serial_subtractor: RTL and testbench

//   Multi-digit BCD subtractor, digit-serial, LSD first, one digit per clock.

---
 rtl/bcd_serial_subtractor_pkg.sv | 19 +
 rtl/bcd_digit_sub.sv | 25 ++
 rtl/bcd_serial_subtractor.sv | 101 ++++++++++
 tb/tb_bcd_serial_subtractor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared definitions for the digit-serial BCD subtractor: FSM states,
// BCD digit limits and the index-counter width helper.
package bcd_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam int         BCD_RADIX = 10;

  // Digit index width: clog2(digits), never narrower than one bit.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtract with borrow-in/out and an
// invalid-digit flag for operands above 9.
module bcd_digit_sub
  import bcd_serial_subtractor_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo,
  output logic       inv
);

  // t spans [-16, 15], so 6-bit two's complement holds it without overflow.
  logic [5:0] t;

  // Raw difference, borrow detection and radix-10 correction of the digit.
  always_comb begin
    t   = {2'b00, a_d} - {2'b00, b_d} - {5'b00000, bi};
    bo  = ($signed(t) < 6'sd0);
    d   = bo ? (t[3:0] + 4'(BCD_RADIX)) : t[3:0];
    inv = (a_d > BCD_MAX) || (b_d > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor, least significant digit first, one digit per
// clock: diff = a - b - bin, with start/busy/done handshake.
module bcd_serial_subtractor
  import bcd_serial_subtractor_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                bout,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = idx_width(DIGITS);

  state_t          state;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic            borrow;

  logic [3:0]      dig;
  logic            dig_bo;
  logic            dig_inv;

  // Operands are shifted right each digit so the current digit is always at [3:0].
  bcd_digit_sub u_digit (
    .a_d (a_sh[3:0]),
    .b_d (b_sh[3:0]),
    .bi  (borrow),
    .d   (dig),
    .bo  (dig_bo),
    .inv (dig_inv)
  );

  // Control FSM with operand shift registers, digit index and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            idx    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          diff[4*idx +: 4] <= dig;
          borrow           <= dig_bo;
          err              <= err | dig_inv;
          a_sh             <= a_sh >> 4;
          b_sh             <= b_sh >> 4;
          if (idx == IW'(DIGITS - 1)) begin
            bout  <= dig_bo;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor: a 4-digit and a 1-digit
// instance, table-driven vectors plus hand-written handshake/reset sequences.
module tb_bcd_serial_subtractor;

  logic        clk;
  logic        rst;

  logic        start4, bin4;
  logic [15:0] a4, b4;
  logic        busy4, done4, bout4, err4;
  logic [15:0] diff4;

  logic        start1, bin1;
  logic [3:0]  a1, b1;
  logic        busy1, done1, bout1, err1;
  logic [3:0]  diff1;

  bit          sel;
  logic        cur_busy, cur_done, cur_bout, cur_err;
  logic [15:0] cur_diff;

  int n_cmp;
  int n_bad;

  bcd_serial_subtractor #(.DIGITS(4)) dut4 (
    .clk (clk), .rst (rst), .start (start4), .a (a4), .b (b4), .bin (bin4),
    .busy (busy4), .done (done4), .diff (diff4), .bout (bout4), .err (err4)
  );

  bcd_serial_subtractor #(.DIGITS(1)) dut1 (
    .clk (clk), .rst (rst), .start (start1), .a (a1), .b (b1), .bin (bin1),
    .busy (busy1), .done (done1), .diff (diff1), .bout (bout1), .err (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    cur_busy = sel ? busy1 : busy4;
    cur_done = sel ? done1 : done4;
    cur_bout = sel ? bout1 : bout4;
    cur_err  = sel ? err1  : err4;
    cur_diff = sel ? {12'h000, diff1} : diff4;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        err;
    bit          chk_val;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one start, then waits (bounded) for done; lat = edges after the start edge.
  task automatic run_op(input bit s, input logic [15:0] av, input logic [15:0] bv,
                        input logic bv_in, output int lat);
    @(negedge clk);
    sel = s;
    if (s) begin
      a1 = av[3:0]; b1 = bv[3:0]; bin1 = bv_in; start1 = 1'b1;
    end else begin
      a4 = av; b4 = bv; bin4 = bv_in; start4 = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    chk("busy_after_start", {31'd0, cur_busy}, 32'd1);
    lat = 0;
    while (!cur_done && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_pulse_end(input string name);
    @(negedge clk);
    chk({name, "_done_low"}, {31'd0, cur_done}, 32'd0);
    chk({name, "_busy_low"}, {31'd0, cur_busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [15:0] got;

    n_cmp = 0; n_bad = 0;
    sel = 1'b0;
    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;

    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{16'h1000, 16'h0001, 1'b1, 16'h0998, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h0017, 16'h0042, 1'b0, 16'h9975, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'h000A, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{16'h5000, 16'h4999, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_diff", {16'd0, diff4}, 32'd0);
    chk("rst_flags", {27'd0, busy4, done4, bout4, err4, busy1}, 32'd0);
    rst = 1'b0;

    // Table-driven operations on the 4-digit instance.
    for (int i = 0; i < 10; i++) begin
      run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd4);
      chk($sformatf("v%0d_err", i), {31'd0, cur_err}, {31'd0, vecs[i].err});
      if (vecs[i].chk_val) begin
        chk($sformatf("v%0d_diff", i), {16'd0, cur_diff}, {16'd0, vecs[i].diff});
        chk($sformatf("v%0d_bout", i), {31'd0, cur_bout}, {31'd0, vecs[i].bout});
      end
      check_pulse_end($sformatf("v%0d", i));
    end

    // Results hold while idle even if operand inputs change.
    a4 = 16'h1234; b4 = 16'h0034;
    repeat (3) @(negedge clk);
    chk("hold_diff", {16'd0, diff4}, 32'h9999);
    chk("hold_bout", {31'd0, bout4}, 32'd1);

    // Start held during RUN with new operands: ignored, one done pulse.
    @(negedge clk);
    sel = 1'b0;
    a4 = 16'h0042; b4 = 16'h0017; bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a4 = 16'h9999; b4 = 16'h0000; bin4 = 1'b1;
    pulses = 0;
    got = '0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (done4) begin
        pulses++;
        got = diff4;
      end
      if (j == 1) start4 = 1'b0;
    end
    chk("ignore_pulses", pulses, 32'd1);
    chk("ignore_diff", {16'd0, got}, 32'h0025);
    chk("ignore_hold", {16'd0, diff4}, 32'h0025);

    // Reset while digit 2 is pending.
    @(negedge clk);
    a4 = 16'h9999; b4 = 16'h0001; bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst_partial", {16'd0, diff4}, 32'h0098);
    rst = 1'b1;
    #1;
    chk("mid_rst_diff", {16'd0, diff4}, 32'd0);
    chk("mid_rst_flags", {28'd0, busy4, done4, bout4, err4}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (done4) pulses++;
    end
    chk("rst_no_done", pulses, 32'd0);
    run_op(1'b0, 16'h0005, 16'h0003, 1'b0, lat);
    chk("post_rst_latency", lat, 32'd4);
    chk("post_rst_diff", {16'd0, cur_diff}, 32'h0002);
    chk("post_rst_bout", {31'd0, cur_bout}, 32'd0);

    // Single-digit instance.
    run_op(1'b1, 16'h0003, 16'h0007, 1'b0, lat);
    chk("d1_latency", lat, 32'd1);
    chk("d1_diff", {16'd0, cur_diff}, 32'h0006);
    chk("d1_bout", {31'd0, cur_bout}, 32'd1);
    check_pulse_end("d1");
    run_op(1'b1, 16'h0009, 16'h0004, 1'b1, lat);
    chk("d1b_diff", {16'd0, cur_diff}, 32'h0004);
    chk("d1b_bout", {31'd0, cur_bout}, 32'd0);
    chk("d1b_err", {31'd0, cur_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
